// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: XLEN, NOP encoding, fetch FSM states and the output slot.
package if_fetch_stage_pkg;
  localparam int          XLEN   = 64;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_slot_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register: redirect (word-aligned) has priority over sequential +4 advance.
module if_pc_gen
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= {redirect_target[XLEN-1:2], 2'b00};
    else if (advance)  pc <= pc_plus4(pc);
  end
endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: one-outstanding imem fetch FSM plus a single-entry output slot feeding IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_IDen,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_PCaddress,
  output logic [31:0] IF_Instruction,
  output logic        IF_valid
);
  fetch_state_t state, state_nxt;
  fetch_slot_t  slot;
  logic [63:0]  pc;
  logic         rsp_take;

  // A response is only ever taken in WAIT, where the slot is guaranteed empty.
  assign rsp_take = (state == WAIT) & imem_rvalid & ~redirect;

  if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .advance         (rsp_take),
    .pc              (pc)
  );

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      unique case (state)
        REQ:     state_nxt = imem_gnt    ? DRAIN : REQ;
        WAIT:    state_nxt = imem_rvalid ? REQ   : DRAIN;
        DRAIN:   state_nxt = imem_rvalid ? REQ   : DRAIN;
        default: state_nxt = REQ;
      endcase
    end else begin
      unique case (state)
        IDLE:    state_nxt = REQ;
        REQ:     if (imem_gnt)    state_nxt = WAIT;
        // After a load the slot is full; refetch only once it has been consumed.
        WAIT:    if (imem_rvalid) state_nxt = HOLD;
        HOLD:    if (IF_IDen)     state_nxt = REQ;
        DRAIN:   if (imem_rvalid) state_nxt = REQ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= '{pc: '0, instr: NOP_INSTR};
      IF_valid <= 1'b0;
    end else if (redirect) begin
      slot.instr <= NOP_INSTR;
      IF_valid   <= 1'b0;
    end else if (rsp_take) begin
      slot     <= '{pc: pc, instr: imem_rdata};
      IF_valid <= 1'b1;
    end else if (IF_valid & IF_IDen) begin
      slot.instr <= NOP_INSTR;
      IF_valid   <= 1'b0;
    end
  end

  assign IF_PCaddress   = slot.pc;
  assign IF_Instruction = slot.instr;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency imem model.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IF_IDen = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] IF_PCaddress;
  logic [31:0] IF_Instruction;
  logic        IF_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cnt     = 0;
  logic [63:0] paddr = '0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .IF_IDen(IF_IDen), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_PCaddress(IF_PCaddress), .IF_Instruction(IF_Instruction), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  // Memory grants immediately; data arrives lat cycles after the grant and is not reset.
  assign imem_gnt    = imem_req;
  assign imem_rvalid = (cnt == 1);
  assign imem_rdata  = paddr[31:0] ^ 32'hA500_0000;

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      cnt   <= lat;
      paddr <= imem_addr;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    step();
    while (!IF_valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_to"}, {63'd0, IF_valid}, 64'd1);
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    step();
    while (!imem_req && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_to"}, {63'd0, imem_req}, 64'd1);
  endtask

  initial begin
    logic ok;
    int   reqs;
    repeat (2) step();
    chk("rst_req",   {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, IF_valid}, 64'd0);
    chk("rst_instr", {32'd0, IF_Instruction}, {32'd0, NOP});
    chk("rst_pc",    IF_PCaddress, 64'd0);

    // Sequential fetch from RESET_PC
    rst = 1'b0;
    step();
    chk("first_req",  {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'd0);
    step(); step();
    chk("first_valid", {63'd0, IF_valid}, 64'd1);
    chk("first_pc",    IF_PCaddress, 64'd0);
    chk("first_instr", {32'd0, IF_Instruction}, 64'h0000_0000_A500_0000);
    wait_valid("seq4");
    chk("seq4_pc", IF_PCaddress, 64'h4);
    wait_valid("seq8");
    chk("seq8_pc", IF_PCaddress, 64'h8);

    // Stall five cycles holding PC 0x8
    IF_IDen = 1'b0;
    ok = 1'b1;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!IF_valid || IF_PCaddress != 64'h8 || IF_Instruction != 32'hA500_0008) ok = 1'b0;
      if (imem_req) reqs++;
    end
    chk("stall_hold", {63'd0, ok}, 64'd1);
    chk("stall_reqs", {63'd0, reqs > 1}, 64'd0);
    IF_IDen = 1'b1;
    wait_valid("resume");
    chk("resume_pc",    IF_PCaddress, 64'hC);
    chk("resume_instr", {32'd0, IF_Instruction}, 64'h0000_0000_A500_000C);

    // Redirect while waiting on a slow response
    lat = 3;
    wait_req("slow");
    chk("slow_addr", imem_addr, 64'h10);
    step();
    redirect = 1'b1;
    redirect_target = 64'h1002;
    step();
    redirect = 1'b0;
    chk("drain1_req",   {63'd0, imem_req}, 64'd0);
    chk("drain1_valid", {63'd0, IF_valid}, 64'd0);
    step();
    chk("drain2_req",   {63'd0, imem_req}, 64'd0);
    chk("drain2_rv",    {63'd0, imem_rvalid}, 64'd1);
    step();
    chk("drain_valid", {63'd0, IF_valid}, 64'd0);
    chk("redir_req",   {63'd0, imem_req}, 64'd1);
    chk("redir_addr",  imem_addr, 64'h1000);
    lat = 1;
    wait_valid("redir");
    chk("redir_pc",    IF_PCaddress, 64'h1000);
    chk("redir_instr", {32'd0, IF_Instruction}, 64'h0000_0000_A500_1000);

    // Redirect coinciding with rvalid: no DRAIN, data dropped
    wait_req("coin");
    step();
    chk("coin_rv", {63'd0, imem_rvalid}, 64'd1);
    redirect = 1'b1;
    redirect_target = 64'h2000;
    step();
    redirect = 1'b0;
    chk("coin_valid", {63'd0, IF_valid}, 64'd0);
    chk("coin_req",   {63'd0, imem_req}, 64'd1);
    chk("coin_addr",  imem_addr, 64'h2000);
    wait_valid("coin");
    chk("coin_pc",    IF_PCaddress, 64'h2000);
    chk("coin_instr", {32'd0, IF_Instruction}, 64'h0000_0000_A500_2000);

    // PC wrap at top of address space
    redirect = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_req",  {63'd0, imem_req}, 64'd1);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid("wrap");
    chk("wrap_pc",    IF_PCaddress, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", {32'd0, IF_Instruction}, 64'h0000_0000_5AFF_FFFC);
    wait_req("wrap0");
    chk("wrap0_addr", imem_addr, 64'h0);
    wait_valid("wrap0");

    // Reset during WAIT; the late response must be ignored
    redirect = 1'b1;
    redirect_target = 64'h3000;
    lat = 3;
    step();
    redirect = 1'b0;
    chk("pre_rst_addr", imem_addr, 64'h3000);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_req",   {63'd0, imem_req}, 64'd0);
    chk("mid_rst_valid", {63'd0, IF_valid}, 64'd0);
    chk("mid_rst_instr", {32'd0, IF_Instruction}, {32'd0, NOP});
    chk("mid_rst_pc",    IF_PCaddress, 64'd0);
    step();
    rst = 1'b0;
    lat = 1;
    wait_req("post_rst");
    chk("post_rst_addr", imem_addr, 64'h0);
    wait_valid("post_rst");
    chk("post_rst_pc",    IF_PCaddress, 64'h0);
    chk("post_rst_instr", {32'd0, IF_Instruction}, 64'h0000_0000_A500_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
